// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared constants and helpers for the single-clock FIFO  | Rev 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int c_FWFT_OFF = 0;
   localparam int c_FWFT_ON  = 1;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 4) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// fifo_ram : simple dual-port RAM, registered or asynchronous read  | Rev 1.0
// ============================================================================
`default_nettype none

module fifo_ram
   import fifo_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int REG_RD = 1,
   localparam int ASIZE = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [ASIZE-1:0] i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [ASIZE-1:0] i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Storage is deliberately left unreset so it maps onto RAM primitives.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   generate
      if (REG_RD != 0) begin : g_reg_rd
         logic [WIDTH-1:0] r_rdata;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)       r_rdata <= '0;
            else if (i_re) r_rdata <= r_mem[i_raddr];
         end

         assign o_rdata = r_rdata;
      end else begin : g_async_rd
         assign o_rdata = r_mem[i_raddr];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/fifo_sync_prog.sv
// ============================================================================
// fifo_sync_prog : single-clock FIFO, level count, thresholds, FWFT  | Rev 1.0
// ============================================================================
`default_nettype none

module fifo_sync_prog
   import fifo_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int FWFT   = c_FWFT_OFF,
   localparam int ASIZE = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             almost_full,
   output logic             overflow,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             empty,
   output logic             almost_empty,
   output logic             underflow,
   output logic [ASIZE:0]   level,
   input  logic [ASIZE:0]   af_thresh,
   input  logic [ASIZE:0]   ae_thresh,
   input  logic             clr_err
);

   localparam bit           c_DEPTH_OK  = depth_ok(DEPTH);
   localparam logic [ASIZE:0] c_LEVEL_MAX = (ASIZE + 1)'(DEPTH);
   localparam int           c_REG_RD    = (FWFT == c_FWFT_OFF) ? 1 : 0;

   generate
      if (!c_DEPTH_OK) begin : g_bad_depth
         $error("fifo_sync_prog: DEPTH must be a power of two and >= 4");
      end
   endgenerate

   logic [ASIZE-1:0] r_wr_ptr;
   logic [ASIZE-1:0] r_rd_ptr;
   logic [ASIZE:0]   r_level;
   logic             r_overflow;
   logic             r_underflow;
   logic             w_wr_acc;
   logic             w_rd_acc;

   // Acceptance looks only at registered occupancy, never at the opposite port.
   assign w_wr_acc = wr_en && !full;
   assign w_rd_acc = rd_en && !empty;

   assign level        = r_level;
   assign full         = (r_level == c_LEVEL_MAX);
   assign empty        = (r_level == '0);
   assign almost_full  = (r_level >= af_thresh);
   assign almost_empty = (r_level <= ae_thresh);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= r_level + (ASIZE + 1)'(w_wr_acc) - (ASIZE + 1)'(w_rd_acc);
         // A fresh error outranks a coincident clear.
         if (wr_en && full)  r_overflow  <= 1'b1;
         else if (clr_err)   r_overflow  <= 1'b0;
         if (rd_en && empty) r_underflow <= 1'b1;
         else if (clr_err)   r_underflow <= 1'b0;
      end
   end

   fifo_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .REG_RD (c_REG_RD)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (wr_data),
      .i_re    (w_rd_acc),
      .i_raddr (r_rd_ptr),
      .o_rdata (rd_data)
   );

   generate
      if (FWFT == c_FWFT_OFF) begin : g_std_valid
         logic r_rd_valid;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_rd_valid <= 1'b0;
            else     r_rd_valid <= w_rd_acc;
         end

         assign rd_valid = r_rd_valid;
      end else begin : g_fwft_valid
         assign rd_valid = !empty;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_prog.sv
// ============================================================================
// tb_fifo_sync_prog : directed self-checking bench, standard + FWFT  | Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_sync_prog;

   logic       clk;
   logic       rst;

   logic       s_wr_en, s_rd_en, s_clr_err;
   logic [7:0] s_wr_data, s_rd_data;
   logic       s_full, s_af, s_ovf, s_rd_valid, s_empty, s_ae, s_udf;
   logic [4:0] s_level, s_af_th, s_ae_th;

   logic       f_wr_en, f_rd_en, f_clr_err;
   logic [7:0] f_wr_data, f_rd_data;
   logic       f_full, f_af, f_ovf, f_rd_valid, f_empty, f_ae, f_udf;
   logic [4:0] f_level, f_af_th, f_ae_th;

   int n_chk = 0;
   int n_err = 0;

   fifo_sync_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
      .clk(clk), .rst(rst),
      .wr_en(s_wr_en), .wr_data(s_wr_data), .full(s_full), .almost_full(s_af),
      .overflow(s_ovf), .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
      .empty(s_empty), .almost_empty(s_ae), .underflow(s_udf), .level(s_level),
      .af_thresh(s_af_th), .ae_thresh(s_ae_th), .clr_err(s_clr_err)
   );

   fifo_sync_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst),
      .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full), .almost_full(f_af),
      .overflow(f_ovf), .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
      .empty(f_empty), .almost_empty(f_ae), .underflow(f_udf), .level(f_level),
      .af_thresh(f_af_th), .ae_thresh(f_ae_th), .clr_err(f_clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] wv(input int k);
      return 8'(k * 13 + 1);
   endfunction

   initial begin
      rst = 1'b1;
      s_wr_en = 0; s_rd_en = 0; s_clr_err = 0; s_wr_data = '0;
      f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = '0;
      s_af_th = 5'd12; s_ae_th = 5'd2;
      f_af_th = 5'd12; f_ae_th = 5'd2;

      // Reset values
      #2;
      chk("rst_level",    32'(s_level),    32'd0);
      chk("rst_empty",    32'(s_empty),    32'd1);
      chk("rst_full",     32'(s_full),     32'd0);
      chk("rst_ae",       32'(s_ae),       32'd1);
      chk("rst_af",       32'(s_af),       32'd0);
      chk("rst_ovf",      32'(s_ovf),      32'd0);
      chk("rst_udf",      32'(s_udf),      32'd0);
      chk("rst_rd_valid", 32'(s_rd_valid), 32'd0);
      chk("rst_rd_data",  32'(s_rd_data),  32'd0);
      step();
      step();
      rst = 1'b0;

      // FWFT: word visible the cycle after its write, no rd_en needed
      f_wr_en = 1; f_wr_data = 8'hA5;
      step();
      f_wr_en = 0;
      chk("fwft_empty_after_wr", 32'(f_empty),    32'd0);
      chk("fwft_head_a5",        32'(f_rd_data),  32'h A5);
      chk("fwft_valid",          32'(f_rd_valid), 32'd1);
      f_rd_en = 1;
      step();
      f_rd_en = 0;
      chk("fwft_empty_after_pop", 32'(f_empty),    32'd1);
      chk("fwft_valid_after_pop", 32'(f_rd_valid), 32'd0);
      f_wr_en = 1; f_wr_data = 8'hB1;
      step();
      f_wr_data = 8'hB2;
      step();
      f_wr_en = 0;
      chk("fwft_head_b1",  32'(f_rd_data), 32'h B1);
      chk("fwft_level_2",  32'(f_level),   32'd2);
      f_rd_en = 1;
      step();
      chk("fwft_head_b2",  32'(f_rd_data), 32'h B2);
      chk("fwft_level_1",  32'(f_level),   32'd1);
      step();
      f_rd_en = 0;
      chk("fwft_drained",  32'(f_empty),   32'd1);

      // Fill standard FIFO
      s_wr_en = 1;
      for (int i = 0; i < 16; i++) begin
         s_wr_data = 8'(i);
         step();
         chk("fill_level", 32'(s_level), 32'(i + 1));
         chk("fill_af",    32'(s_af),    32'((i + 1) >= 12));
         chk("fill_full",  32'(s_full),  32'((i + 1) == 16));
      end
      s_wr_data = 8'hFF;
      step();
      s_wr_en = 0;
      chk("ovf_set",        32'(s_ovf),   32'd1);
      chk("ovf_level_16",   32'(s_level), 32'd16);

      // Drain
      s_rd_en = 1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("drain_data",  32'(s_rd_data),  32'(i));
         chk("drain_valid", 32'(s_rd_valid), 32'd1);
         chk("drain_level", 32'(s_level),    32'(15 - i));
         chk("drain_empty", 32'(s_empty),    32'(i == 15));
         chk("drain_ae",    32'(s_ae),       32'((15 - i) <= 2));
      end
      step();
      s_rd_en = 0;
      chk("udf_set",        32'(s_udf),      32'd1);
      chk("udf_data_hold",  32'(s_rd_data),  32'h0F);
      chk("udf_no_valid",   32'(s_rd_valid), 32'd0);
      s_clr_err = 1;
      step();
      s_clr_err = 0;
      chk("clr_ovf", 32'(s_ovf), 32'd0);
      chk("clr_udf", 32'(s_udf), 32'd0);

      // Simultaneous read/write at level 8
      s_wr_en = 1;
      for (int i = 0; i < 8; i++) begin
         s_wr_data = 8'(8'h20 + i);
         step();
      end
      s_wr_data = 8'h28; s_rd_en = 1;
      step();
      s_wr_en = 0;
      chk("rw8_level", 32'(s_level),   32'd8);
      chk("rw8_data",  32'(s_rd_data), 32'h20);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("rw8_order", 32'(s_rd_data), 32'(8'h20 + i));
      end
      s_rd_en = 0;
      chk("rw8_empty", 32'(s_empty), 32'd1);

      // Simultaneous read/write at full
      s_wr_en = 1;
      for (int i = 0; i < 16; i++) begin
         s_wr_data = 8'(8'h40 + i);
         step();
      end
      s_wr_data = 8'h99; s_rd_en = 1;
      step();
      s_wr_en = 0;
      chk("rwfull_level", 32'(s_level),   32'd15);
      chk("rwfull_ovf",   32'(s_ovf),     32'd1);
      chk("rwfull_data",  32'(s_rd_data), 32'h40);
      for (int i = 1; i <= 15; i++) begin
         step();
         chk("rwfull_order", 32'(s_rd_data), 32'(8'h40 + i));
      end
      s_rd_en = 0;
      chk("rwfull_empty", 32'(s_empty), 32'd1);
      s_clr_err = 1;
      step();
      s_clr_err = 0;

      // Simultaneous read/write at empty
      s_wr_en = 1; s_wr_data = 8'h77; s_rd_en = 1;
      step();
      s_wr_en = 0;
      chk("rwempty_level", 32'(s_level),    32'd1);
      chk("rwempty_udf",   32'(s_udf),      32'd1);
      chk("rwempty_valid", 32'(s_rd_valid), 32'd0);
      step();
      s_rd_en = 0;
      chk("rwempty_data",  32'(s_rd_data),  32'h77);
      chk("rwempty_lvl0",  32'(s_level),    32'd0);
      s_clr_err = 1;
      step();
      s_clr_err = 0;

      // Wrap-around with a standing offset of 5 words
      s_wr_en = 1;
      for (int k = 0; k < 5; k++) begin
         s_wr_data = wv(k);
         step();
      end
      s_rd_en = 1;
      for (int k = 0; k < 40; k++) begin
         s_wr_data = wv(k + 5);
         step();
         chk("wrap_data",  32'(s_rd_data), 32'(wv(k)));
         chk("wrap_level", 32'(s_level),   32'd5);
      end
      s_wr_en = 0;
      for (int k = 40; k < 45; k++) begin
         step();
         chk("wrap_tail", 32'(s_rd_data), 32'(wv(k)));
      end
      s_rd_en = 0;
      chk("wrap_empty", 32'(s_empty), 32'd1);

      // Overflow set wins over a coincident clear
      s_wr_en = 1;
      for (int i = 0; i < 16; i++) begin
         s_wr_data = 8'(8'hC0 + i);
         step();
      end
      s_clr_err = 1;
      step();
      s_wr_en = 0;
      chk("ovf_beats_clr", 32'(s_ovf), 32'd1);
      step();
      s_clr_err = 0;
      chk("ovf_cleared",   32'(s_ovf), 32'd0);

      // Asynchronous reset mid-stream, checked between clock edges
      s_wr_en = 1; s_rd_en = 1; s_wr_data = 8'h5A;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_level", 32'(s_level), 32'd0);
      chk("arst_empty", 32'(s_empty), 32'd1);
      chk("arst_full",  32'(s_full),  32'd0);
      chk("arst_valid", 32'(s_rd_valid), 32'd0);
      #1;
      rst = 1'b0;
      s_wr_en = 0; s_rd_en = 0;
      step();
      chk("post_rst_empty", 32'(s_empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_sync_prog.md
# fifo_sync_prog

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for same-domain buffering. Adds an occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. Sits between same-clock producer/consumer stages such as packet parsers, DMA staging and rate-smoothing buffers.

## Interface
- WIDTH, 8, data word width (≥1)
- DEPTH, 16, storage words; power of two, ≥4; ASIZE = log2(DEPTH)
- FWFT, 0, 0 = standard registered read; 1 = first-word fall-through

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- full  out  1  level == DEPTH
- almost_full  out  1  level ≥ af_thresh
- overflow  out  1  sticky: write attempted while full
- rd_en  in  1  read request (standard) / pop head word (FWFT)
- rd_data  out  WIDTH  read data
- rd_valid  out  1  rd_data holds a newly read word (standard); equals !empty (FWFT)
- empty  out  1  level == 0
- almost_empty  out  1  level ≤ ae_thresh
- underflow  out  1  sticky: read attempted while empty
- level  out  ASIZE+1  stored word count, 0..DEPTH
- af_thresh  in  ASIZE+1  almost-full threshold, quasi-static
- ae_thresh  in  ASIZE+1  almost-empty threshold, quasi-static
- clr_err  in  1  clears overflow and underflow

## Operation
- Write accepted iff wr_en && !full; word stored at wr_ptr, wr_ptr increments mod DEPTH.
- Read accepted iff rd_en && !empty; rd_ptr increments mod DEPTH.
- full/empty gate on registered state only. A write while full is rejected even if a read is accepted the same cycle. A read while empty is rejected even if a write is accepted the same cycle.
- level next = level + wr_acc − rd_acc; simultaneous accepted read and write leaves level unchanged.
- Pointers are ASIZE bits and wrap naturally. Occupancy comes from level, not pointer comparison.
- full, empty, almost_full, almost_empty are combinational compares on the registered level and live thresholds. af_thresh = 0 gives almost_full constantly 1; ae_thresh ≥ DEPTH gives almost_empty constantly 1.
- overflow set on wr_en && full; underflow set on rd_en && empty. Both hold until clr_err. Set wins over clr_err in the same cycle.
- Standard mode (FWFT=0): rd_data registered from mem[rd_ptr] on an accepted read. rd_valid pulses 1 the next cycle. rd_data holds its value otherwise.
- FWFT mode: rd_data = mem[rd_ptr] combinationally while !empty, undefined when empty. rd_en acknowledges/pops the head word.
- Reset: pointers, level, overflow, underflow, rd_valid, rd_data cleared to 0. Memory contents not cleared. Reset mid-operation discards all stored words.

## Timing
- Reset values: level 0, empty 1, full 0, almost_empty 1, almost_full (0 ≥ af_thresh), overflow 0, underflow 0, rd_valid 0, rd_data 0.
- Write at edge N: level, empty and full update at N+1.
  - Standard mode: the word is readable by rd_en sampled at N+1 and appears on rd_data at N+2.
  - FWFT mode: the word appears on rd_data during cycle N+1.
- Read latency: standard 1 cycle from rd_en to rd_data/rd_valid. FWFT 0 cycles; the next word is presented the cycle after the pop.
- Back-to-back: one write and one read per cycle sustained; full throughput at any level 1..DEPTH−1.
- Error flags assert the cycle after the offending request.

## Structure
- Package fifo_pkg holds:
  - the ptr_w(DEPTH) helper function returning ASIZE;
  - a localparam check that DEPTH is a power of two and ≥4;
  - the FWFT mode encoding constants.
- Sub-module fifo_ram: single-clock simple dual-port RAM, WIDTH × DEPTH, with a parameter REG_RD.
  - REG_RD=1: registered read port (block RAM), used in standard mode.
  - REG_RD=0: asynchronous read port (distributed RAM), used in FWFT mode.
- Top level owns pointers, level counter, flag compares and error logic.

## Test plan
- Reset then fill (DEPTH=16, FWFT=0): write 0x00..0x0F over 16 cycles.
  - Required: level steps 1..16, full at cycle 17, almost_full once level ≥ af_thresh=12.
  - Required: a 17th write sets overflow and level stays 16.
- Drain after fill: rd_en for 16 cycles.
  - Required: rd_data 0x00..0x0F, each one cycle after its rd_en, rd_valid high each cycle, empty once level reaches 0.
  - Required: an extra rd_en sets underflow and rd_data holds 0x0F.
- Simultaneous read and write:
  - At level 8: level stays 8 and data order is preserved.
  - At full: the read is accepted, the write rejected, overflow set, level 15.
  - At empty: the write is accepted, the read rejected, underflow set, level 1.
- Wrap-around: 40 write/read pairs with offset level 5; the output sequence matches the input with no loss across three pointer wraps.
- FWFT=1: write 0xA5 at cycle N.
  - Required: empty=0 and rd_data=0xA5 in cycle N+1 with no rd_en.
  - Required: a pop at N+1 makes empty=1 at N+2.
- clr_err coincident with a new overflow: overflow stays 1. A later clr_err alone clears it. Async rst asserted mid-stream: level 0 and empty 1 immediately, with no clock edge.
